jt7759_dbuf: RTL and testbench
==============================

JT7759_DBUF -- requirements
Module: jt7759_dbuf

Interface
REQ-001 Parameter DW, default 8, data width in bits.
REQ-002 Parameter DEPTH, default 4, FIFO entries (power of two, 2..64).
REQ-003 Parameter AW, default 17, ROM address width.
REQ-004 Parameter THRESH, default 1, minimum free entries before a new request is raised (1..DEPTH).
REQ-005 Parameter GAP, default 31, minimum cen ticks between accepted transfers and the next request.
REQ-006 clk  in  1  sole clock.
REQ-007 rstn  in  1  asynchronous reset, active-low.
REQ-008 cen  in  1  clock enable for the gap counter.
REQ-009 mdn  in  1  1 = ROM master mode, 0 = slave-write mode.
REQ-010 flush  in  1  synchronous clear of buffer state.
REQ-011 base_ld  in  1 / base_addr  in  AW  load the ROM pointer.
REQ-012 rd_req  in  1  one-cycle consumer read request.
REQ-013 rd_data  out  DW / rd_ok  out  1  read data and its one-cycle valid strobe.
REQ-014 rom_cs  out  1 / rom_addr  out  AW / rom_data  in  DW / rom_ok  in  1  ROM port.
REQ-015 cs  in  1 / wrn  in  1 / din  in  DW  slave write port.
REQ-016 drqn  out  1  data request, active-low.
REQ-017 level  out  clog2(DEPTH)+1 / empty  out  1 / full  out  1 / ovf  out  1 (sticky drop flag).

Function
REQ-018 The storage SHALL be a circular buffer with read and write pointers that wrap modulo DEPTH; level = writes minus reads, 0..DEPTH.
REQ-019 The request FSM SHALL have the states IDLE, REQ and GAP; drqn SHALL be low only in REQ.
REQ-020 IDLE->REQ SHALL occur when flush=0, base_ld=0 and DEPTH-level >= THRESH.
REQ-021 In REQ, an accept SHALL be mdn&rom_ok (rom_cs=1 throughout REQ in master mode) or ~mdn&cs&~wrn; an accept SHALL write the data, advance the write pointer, and move REQ->GAP with drqn high on the next cycle.
REQ-022 GAP SHALL load a counter with GAP on entry, decrement it on each cen, and return to IDLE when it reaches 0; GAP=0 SHALL return to IDLE on the next cycle.
REQ-023 rom_cs SHALL equal mdn & (state==REQ).
REQ-024 rom_addr SHALL increment by 1 (wrapping at 2^AW) on each ROM-mode accept.
REQ-025 A slave write (cs&~wrn) outside REQ, or any write while full, SHALL be dropped and SHALL set ovf until flush or reset.
REQ-026 rd_req with level>0 SHALL produce rd_data and rd_ok=1 on the next cycle, advancing the read pointer.
REQ-027 rd_req with level=0 SHALL be held pending; the pending read SHALL be served one cycle after the next accepted write; further rd_req while one is pending SHALL be ignored.
REQ-028 A simultaneous read and accepted write SHALL both complete, with level unchanged.
REQ-029 flush SHALL clear the pointers, level, pending read, ovf and rd_ok, force the FSM to IDLE and drqn high, and leave rom_addr unchanged; flush SHALL dominate all other events in that cycle.
REQ-030 base_ld SHALL load rom_addr<=base_addr and SHALL apply the same clearing as flush in the same cycle.
REQ-031 empty SHALL equal level==0 and full SHALL equal level==DEPTH, both taken from registered state.

Reset
REQ-032 While rstn=0 the block SHALL hold: FSM=IDLE, drqn=1, rom_cs=0, rom_addr=0, rd_data=0, rd_ok=0, level=0, empty=1, full=0, ovf=0, gap counter=0, pending read cleared.
REQ-033 Assertion of rstn mid-transfer SHALL discard any in-flight accept; the first request after release SHALL occur no earlier than the second clk edge.

Structure
REQ-034 The FSM state encoding and the clog2 helper function SHALL live in the shared package jt7759_pkg.
REQ-035 The storage array SHALL be the sub-module jt7759_dbuf_ram (DW x DEPTH, one write port, one registered read port); pointers and the FSM SHALL stay in jt7759_dbuf.

Verification
REQ-036 DEPTH=4, mdn=1, base_addr=0x100 loaded, rom_ok=1 always, GAP=0 -> four accepts, rom_addr=0x104, full=1, drqn held high.
REQ-037 GAP=31, cen every 2nd cycle -> drqn low-to-low spacing of at least 64 clk cycles between successive requests.
REQ-038 mdn=0, slave write 0x5A outside REQ -> data dropped, ovf=1, level unchanged; flush -> ovf=0.
REQ-039 Empty buffer, rd_req pulse, then slave accept of 0xA3 -> rd_ok=1 with rd_data=0xA3 exactly one cycle after the accept.
REQ-040 level=2, rd_req in the same cycle as an accept -> level stays 2, data order preserved across the pointer wrap from 3 to 0.
REQ-041 rstn pulsed low during REQ with rom_ok high -> all outputs at their reset values, no write recorded, rom_addr=0.

Source files
------------

// File: rtl/jt7759_pkg.sv
// Shared types for the jt7759 sample buffer:
// request FSM encoding and the clog2 helper.
package jt7759_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } dbuf_st_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/jt7759_dbuf_if.sv
// Bus bundle of jt7759_dbuf: consumer read port,
// ROM master port, slave write port and drqn.
interface jt7759_dbuf_if #(
  parameter int DW = 8,
  parameter int AW = 17
);
  logic          rd_req;
  logic [DW-1:0] rd_data;
  logic          rd_ok;
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          rom_ok;
  logic          cs;
  logic          wrn;
  logic [DW-1:0] din;
  logic          drqn;

  modport master (
    input  rd_req, rom_data, rom_ok,
    input  cs, wrn, din,
    output rd_data, rd_ok, rom_cs,
    output rom_addr, drqn
  );

  modport slave (
    output rd_req, rom_data, rom_ok,
    output cs, wrn, din,
    input  rd_data, rd_ok, rom_cs,
    input  rom_addr, drqn
  );
endinterface

// File: rtl/jt7759_dbuf_ram.sv
// DW x DEPTH storage, one write port, one registered
// read port (clk, rstn, we/waddr/wdata, re/raddr -> q).
module jt7759_dbuf_ram
  import jt7759_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    we,
  input  logic [clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]           wdata,
  input  logic                    re,
  input  logic [clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]           q
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // write-through lets a read of the slot being
  // written in the same cycle return the new data
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)
      q <= '0;
    else if (re)
      q <= (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/jt7759_dbuf.sv
// Circular sample buffer fed from ROM or slave writes,
// with drqn request FSM, pending read and ovf flag.
module jt7759_dbuf
  import jt7759_pkg::*;
#(
  parameter int DW     = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = 17,
  parameter int THRESH = 1,
  parameter int GAP    = 31
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cen,
  input  logic                  mdn,
  input  logic                  flush,
  input  logic                  base_ld,
  input  logic [AW-1:0]         base_addr,
  jt7759_dbuf_if.master         bus,
  output logic [clog2(DEPTH):0] level,
  output logic                  empty,
  output logic                  full,
  output logic                  ovf
);
  localparam int PW = clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (GAP > 0) ? clog2(GAP + 1) : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] THR_L   = LW'(THRESH);
  localparam logic [CW-1:0] GAP_L   = CW'(GAP);

  dbuf_st_e      st, st_nx;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] gap_cnt;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          pend, armed, ok;
  logic          clr, slv_wr, acc;
  logic          wr_en, rd_fire, drop;

  assign clr     = flush | base_ld;
  assign slv_wr  = bus.cs & ~bus.wrn;
  assign acc     = (st == ST_REQ) &
                   (mdn ? bus.rom_ok : slv_wr);
  assign wr_en   = acc & ~full & ~clr;
  assign drop    = (slv_wr & (st != ST_REQ)) |
                   (acc & full);
  // a pending read is satisfied by the write itself
  assign rd_fire = ~clr & ((pend & wr_en) |
                   (bus.rd_req & ((level != '0) | wr_en)));
  assign wr_data = mdn ? bus.rom_data : bus.din;

  assign empty        = level == '0;
  assign full         = level == DEPTH_L;
  assign bus.rom_cs   = mdn & (st == ST_REQ);
  assign bus.drqn     = st != ST_REQ;
  assign bus.rom_addr = addr;
  assign bus.rd_ok    = ok;

  jt7759_dbuf_ram #(.DW(DW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (rd_fire),
    .raddr (rd_ptr),
    .q     (bus.rd_data)
  );

  always_comb begin
    st_nx = st;
    unique case (st)
      ST_IDLE:
        if (armed && (DEPTH_L - level) >= THR_L)
          st_nx = ST_REQ;
      ST_REQ:
        if (acc) st_nx = ST_GAP;
      ST_GAP:
        if (gap_cnt == '0) st_nx = ST_IDLE;
      default:
        st_nx = ST_IDLE;
    endcase
    if (clr) st_nx = ST_IDLE;
  end

  // armed holds off the first request until the
  // second edge after reset release
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st      <= ST_IDLE;
      armed   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      pend    <= 1'b0;
      ovf     <= 1'b0;
      ok      <= 1'b0;
      gap_cnt <= '0;
      addr    <= '0;
    end else begin
      st    <= st_nx;
      armed <= 1'b1;
      if (clr) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level   <= '0;
        pend    <= 1'b0;
        ovf     <= 1'b0;
        ok      <= 1'b0;
        gap_cnt <= '0;
        if (base_ld) addr <= base_addr;
      end else begin
        if (wr_en)   wr_ptr <= wr_ptr + PW'(1);
        if (rd_fire) rd_ptr <= rd_ptr + PW'(1);
        level <= level + LW'(wr_en) - LW'(rd_fire);
        pend  <= (pend | (bus.rd_req & (level == '0)))
                 & ~wr_en;
        ovf   <= ovf | drop;
        ok    <= rd_fire;
        if (acc & mdn) addr <= addr + AW'(1);
        if (acc)
          gap_cnt <= GAP_L;
        else if (st == ST_GAP && cen && gap_cnt != '0)
          gap_cnt <= gap_cnt - CW'(1);
      end
    end
endmodule

// File: tb/tb_jt7759_dbuf.sv
// Bench for jt7759_dbuf: queue model compared every
// cycle plus directed literal checks.
module tb_jt7759_dbuf;
  logic        clk = 0;
  logic        rstn = 0;
  logic        cen = 0;
  logic        mdn = 1;
  logic        flush = 0;
  logic        base_ld = 0;
  logic [16:0] base_addr = '0;
  logic [2:0]  level;
  logic        empty, full, ovf;

  logic        cen2 = 0;
  logic [2:0]  level2;
  logic        empty2, full2, ovf2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_on = 0;

  jt7759_dbuf_if #(.DW(8), .AW(17)) bus ();
  jt7759_dbuf_if #(.DW(8), .AW(17)) bus2 ();

  assign bus.rom_data  = bus.rom_addr[7:0] + 8'h30;
  assign bus2.rom_data = 8'h77;

  jt7759_dbuf #(
    .DW(8), .DEPTH(4), .AW(17), .THRESH(1), .GAP(0)
  ) dut (
    .clk(clk), .rstn(rstn), .cen(cen), .mdn(mdn),
    .flush(flush), .base_ld(base_ld),
    .base_addr(base_addr), .bus(bus),
    .level(level), .empty(empty), .full(full),
    .ovf(ovf)
  );

  jt7759_dbuf #(
    .DW(8), .DEPTH(4), .AW(17), .THRESH(1), .GAP(31)
  ) dut2 (
    .clk(clk), .rstn(rstn), .cen(cen2), .mdn(1'b1),
    .flush(1'b0), .base_ld(1'b0),
    .base_addr(17'h0), .bus(bus2),
    .level(level2), .empty(empty2), .full(full2),
    .ovf(ovf2)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial forever begin
    @(posedge clk); #1 cen2 = ~cen2;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mq[$];
  bit          m_req, m_armed, m_pend, m_ovf, m_ok;
  int          m_cool;
  logic [7:0]  m_rd;
  logic [16:0] m_addr;

  task automatic m_step();
    int sz;
    bit sw, acc, wen;
    logic [7:0] wd;
    if (!rstn) begin
      mq.delete();
      m_req = 0; m_armed = 0; m_pend = 0;
      m_ovf = 0; m_ok = 0; m_cool = 0;
      m_rd = 8'h00; m_addr = '0;
      return;
    end
    sz  = mq.size();
    sw  = bus.cs && !bus.wrn;
    acc = m_req && (mdn ? bus.rom_ok : sw);
    wen = acc && sz < 4;
    wd  = mdn ? m_addr[7:0] + 8'h30 : bus.din;
    if (flush || base_ld) begin
      mq.delete();
      m_pend = 0; m_ovf = 0; m_ok = 0;
      m_req = 0; m_cool = 0; m_armed = 1;
      if (base_ld) m_addr = base_addr;
      return;
    end
    if ((sw && !m_req) || (acc && !wen)) m_ovf = 1;
    m_ok = 0;
    if (m_pend && wen) begin
      m_ok = 1; m_rd = wd; m_pend = 0;
    end else if (bus.rd_req && sz > 0) begin
      m_ok = 1; m_rd = mq.pop_front();
      if (wen) mq.push_back(wd);
    end else if (bus.rd_req && wen) begin
      m_ok = 1; m_rd = wd;
    end else begin
      if (bus.rd_req) m_pend = 1;
      if (wen) mq.push_back(wd);
    end
    if (acc && mdn) m_addr = m_addr + 17'd1;
    if (m_req) begin
      if (acc) begin m_req = 0; m_cool = 1; end
    end else if (m_cool > 0) m_cool = 0;
    else if (m_armed && 4 - sz >= 1) m_req = 1;
    m_armed = 1;
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    m_step();
  end

  initial forever begin
    @(negedge clk);
    if (rstn && chk_on) begin
      chk("level", level, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == 4);
      chk("ovf", ovf, m_ovf);
      chk("rd_ok", bus.rd_ok, m_ok);
      if (m_ok) chk("rd_data", bus.rd_data, m_rd);
      chk("drqn", bus.drqn, !m_req);
      chk("rom_cs", bus.rom_cs, mdn && m_req);
      chk("rom_addr", bus.rom_addr, m_addr);
    end
  end

  // drqn falling edges of the GAP=31 instance
  int nf = 0, f1 = 0, f2 = 0;
  initial begin
    logic prev;
    prev = 1;
    forever begin
      @(negedge clk);
      if (rstn && prev && !bus2.drqn) begin
        if (nf == 0) f1 = cyc;
        else if (nf == 1) f2 = cyc;
        nf++;
      end
      prev = bus2.drqn;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_req();
    int n = 0;
    while (bus.drqn && n < 20) begin tick(1); n++; end
    if (bus.drqn) begin
      checks++; errors++;
      $display("FAIL wait_req timeout drqn=1 want 0");
    end
  endtask

  task automatic swr(input logic [7:0] d, input bit rd);
    wait_req();
    bus.cs = 1; bus.wrn = 0; bus.din = d;
    bus.rd_req = rd;
    tick(1);
    bus.cs = 0; bus.wrn = 1; bus.rd_req = 0;
  endtask

  task automatic rd(input logic [7:0] exp);
    bus.rd_req = 1;
    tick(1);
    bus.rd_req = 0;
    chk("rd_ok_lit", bus.rd_ok, 1);
    chk("rd_data_lit", bus.rd_data, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_drqn"}, bus.drqn, 1);
    chk({tag, "_rom_cs"}, bus.rom_cs, 0);
    chk({tag, "_rom_addr"}, bus.rom_addr, 0);
    chk({tag, "_rd_data"}, bus.rd_data, 0);
    chk({tag, "_rd_ok"}, bus.rd_ok, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    bus.rd_req = 0; bus.rom_ok = 0;
    bus.cs = 0; bus.wrn = 1; bus.din = '0;
    bus2.rd_req = 0; bus2.rom_ok = 1;
    bus2.cs = 0; bus2.wrn = 1; bus2.din = '0;

    tick(2);
    chk_reset("rst");
    rstn = 1; chk_on = 1;
    tick(1);
    chk("first_edge_drqn", bus.drqn, 1);
    tick(1);
    chk("second_edge_drqn", bus.drqn, 0);

    // ROM fill from 0x100, GAP=0
    base_addr = 17'h100; base_ld = 1;
    tick(1);
    base_ld = 0;
    chk("base_rom_addr", bus.rom_addr, 17'h100);
    chk("base_drqn", bus.drqn, 1);
    bus.rom_ok = 1;
    tick(20);
    chk("fill_rom_addr", bus.rom_addr, 17'h104);
    chk("fill_full", full, 1);
    chk("fill_level", level, 4);
    chk("fill_drqn", bus.drqn, 1);
    bus.rom_ok = 0;
    tick(3);
    chk("full_hold_drqn", bus.drqn, 1);
    for (int i = 0; i < 4; i++) rd(8'h30 + 8'(i));

    // slave write outside REQ is dropped
    mdn = 0;
    flush = 1; tick(1); flush = 0;
    swr(8'h11, 0);
    bus.cs = 1; bus.wrn = 0; bus.din = 8'h5A;
    tick(1);
    bus.cs = 0; bus.wrn = 1;
    chk("drop_ovf", ovf, 1);
    chk("drop_level", level, 1);
    flush = 1; tick(1); flush = 0;
    chk("flush_ovf", ovf, 0);
    chk("flush_level", level, 0);

    // pending read served by next accept
    bus.rd_req = 1; tick(1); bus.rd_req = 0;
    chk("pend_rd_ok", bus.rd_ok, 0);
    swr(8'hA3, 0);
    chk("pend_rd_ok2", bus.rd_ok, 1);
    chk("pend_rd_data", bus.rd_data, 8'hA3);
    chk("pend_level", level, 0);

    // simultaneous read/write across the wrap
    swr(8'hB1, 0);
    swr(8'hB2, 0);
    chk("lvl2", level, 2);
    swr(8'hB3, 1);
    chk("sim1_data", bus.rd_data, 8'hB1);
    chk("sim1_level", level, 2);
    swr(8'hB4, 1);
    chk("sim2_data", bus.rd_data, 8'hB2);
    chk("sim2_level", level, 2);
    rd(8'hB3);
    rd(8'hB4);
    chk("wrap_empty", empty, 1);

    // request spacing with GAP=31, cen every 2nd
    while (nf < 2 && cyc < 800) tick(1);
    if (nf < 2) begin
      checks++; errors++;
      $display("FAIL gap_timeout edges %0d want 2", nf);
    end else begin
      chk("gap_ge64", (f2 - f1) >= 64, 1);
      chk("gap_le65", (f2 - f1) <= 65, 1);
    end

    // reset in the middle of a ROM request
    mdn = 1; bus.rom_ok = 0;
    flush = 1; tick(1); flush = 0;
    wait_req();
    bus.rom_ok = 1; rstn = 0;
    #2;
    chk_reset("midrst");
    tick(2);
    chk("midrst_level", level, 0);
    chk("midrst_addr", bus.rom_addr, 0);
    bus.rom_ok = 0; rstn = 1;
    tick(1);
    chk("rel_edge1_drqn", bus.drqn, 1);
    tick(1);
    chk("rel_edge2_drqn", bus.drqn, 0);
    chk("rel_edge2_cs", bus.rom_cs, 1);
    tick(2);

    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
